// File: rtl/dsd_pkg.sv
// Shared constants and helpers for the DSD-to-PCM decimator.
package dsd_pkg;
  localparam int         CIC_ORDER   = 4;
  localparam logic [7:0] DSD_SILENCE = 8'h69;

  function automatic int cic_width(input int log2_decim);
    return CIC_ORDER * log2_decim + 2;
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int out_w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (value > hi)      return hi;
    else if (value < lo) return lo;
    else                 return value;
  endfunction
endpackage

// File: rtl/dsd_cic.sv
// One channel of 4th-order CIC decimation: +-1 input, scaled and saturated PCM out.
module dsd_cic
  import dsd_pkg::*;
#(
  parameter int LOG2_DECIM = 5,
  parameter int OUT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    tick_i,
  input  logic                    dump_i,
  input  logic                    bit_i,
  output logic signed [OUT_W-1:0] pcm_o
);
  localparam int W     = cic_width(LOG2_DECIM);
  localparam int SHIFT = CIC_ORDER * LOG2_DECIM - (OUT_W - 1);

  typedef logic signed [W-1:0] acc_t;

  acc_t integ_q [CIC_ORDER];
  acc_t integ_d [CIC_ORDER];
  acc_t dly_q   [CIC_ORDER];
  acc_t dly_d   [CIC_ORDER];
  acc_t comb    [CIC_ORDER+1];
  logic signed [63:0]      scaled, limited;
  logic signed [OUT_W-1:0] pcm_q, pcm_d;

  // Integrators chain combinationally, so the comb section sees this tick's sample.
  always_comb begin
    integ_d[0] = integ_q[0] + (bit_i ? acc_t'(1) : acc_t'(-1));
    for (int k = 1; k < CIC_ORDER; k++) integ_d[k] = integ_q[k] + integ_d[k-1];
    comb[0] = integ_d[CIC_ORDER-1];
    for (int k = 0; k < CIC_ORDER; k++) begin
      dly_d[k]   = comb[k];
      comb[k+1]  = comb[k] - dly_q[k];
    end
    scaled  = 64'(comb[CIC_ORDER]) >>> SHIFT;
    limited = sat(scaled, OUT_W);
    pcm_d   = limited[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      integ_q <= '{default: '0};
      dly_q   <= '{default: '0};
      pcm_q   <= '0;
    end else if (clear) begin
      integ_q <= '{default: '0};
      dly_q   <= '{default: '0};
      pcm_q   <= '0;
    end else begin
      if (tick_i) integ_q <= integ_d;
      if (dump_i) begin
        dly_q <= dly_d;
        pcm_q <= pcm_d;
      end
    end
  end

  assign pcm_o = pcm_q;
endmodule

// File: rtl/dsd_decimator.sv
// Interleaved DSD byte fetch, per-bit playout and per-channel CIC decimation to PCM.
module dsd_decimator
  import dsd_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int LOG2_DECIM = 5,
  parameter int OUT_W      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      enable,
  input  logic                      lsb_first,
  input  logic                      dsd_tick,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_data,
  output logic                      pcm_valid,
  output logic [CHANNELS*OUT_W-1:0] pcm,
  output logic [15:0]               underrun_cnt
);
  localparam int            PW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [PW-1:0] LAST_CH = PW'(CHANNELS - 1);

  logic [PW-1:0]            chan_ptr_q, chan_ptr_d;
  logic                     next_full_q, next_full_d;
  logic [CHANNELS-1:0][7:0] cur_q, cur_d, next_q, next_d;
  logic [2:0]               bitpos_q, bitpos_d;
  logic [LOG2_DECIM-1:0]    dec_cnt_q, dec_cnt_d;
  logic                     lsb_q, lsb_d;
  logic [15:0]              under_q, under_d;
  logic                     pcm_valid_q;
  logic                     tick, accept, dump;
  logic [CHANNELS-1:0]      dsd_bit;

  assign in_ready     = !next_full_q;
  assign tick         = dsd_tick & enable & ~clear;
  assign accept       = in_valid & ~next_full_q & ~clear;
  assign dump         = tick & (dec_cnt_q == '1);
  assign pcm_valid    = pcm_valid_q;
  assign underrun_cnt = under_q;

  // A byte-boundary load needs next_full, an accept needs !next_full, so they never collide.
  always_comb begin
    chan_ptr_d  = chan_ptr_q;
    next_full_d = next_full_q;
    cur_d       = cur_q;
    next_d      = next_q;
    bitpos_d    = bitpos_q;
    dec_cnt_d   = dec_cnt_q;
    lsb_d       = lsb_q;
    under_d     = under_q;
    if (accept) begin
      next_d[chan_ptr_q] = in_data;
      if (chan_ptr_q == LAST_CH) begin
        chan_ptr_d  = '0;
        next_full_d = 1'b1;
      end else begin
        chan_ptr_d = chan_ptr_q + 1'b1;
      end
    end
    if (tick) begin
      bitpos_d  = bitpos_q + 3'd1;
      dec_cnt_d = dec_cnt_q + 1'b1;
      if (bitpos_q == 3'd7) begin
        lsb_d = lsb_first;
        if (next_full_q) begin
          cur_d       = next_q;
          next_full_d = 1'b0;
        end else begin
          cur_d = {CHANNELS{DSD_SILENCE}};
          if (under_q != 16'hFFFF) under_d = under_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chan_ptr_q  <= '0;
      next_full_q <= 1'b0;
      cur_q       <= {CHANNELS{DSD_SILENCE}};
      next_q      <= '0;
      bitpos_q    <= '0;
      dec_cnt_q   <= '0;
      lsb_q       <= 1'b0;
      pcm_valid_q <= 1'b0;
      under_q     <= '0;
    end else begin
      under_q <= under_d;
      if (clear) begin
        chan_ptr_q  <= '0;
        next_full_q <= 1'b0;
        cur_q       <= {CHANNELS{DSD_SILENCE}};
        next_q      <= '0;
        bitpos_q    <= '0;
        dec_cnt_q   <= '0;
        lsb_q       <= 1'b0;
        pcm_valid_q <= 1'b0;
      end else begin
        chan_ptr_q  <= chan_ptr_d;
        next_full_q <= next_full_d;
        cur_q       <= cur_d;
        next_q      <= next_d;
        bitpos_q    <= bitpos_d;
        dec_cnt_q   <= dec_cnt_d;
        lsb_q       <= lsb_d;
        pcm_valid_q <= dump;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign dsd_bit[c] = cur_q[c][lsb_q ? bitpos_q : 3'd7 - bitpos_q];

    dsd_cic #(.LOG2_DECIM(LOG2_DECIM), .OUT_W(OUT_W)) u_cic (
      .clk    (clk),
      .reset  (reset),
      .clear  (clear),
      .tick_i (tick),
      .dump_i (dump),
      .bit_i  (dsd_bit[c]),
      .pcm_o  (pcm[c*OUT_W +: OUT_W])
    );
  end
endmodule

// File: doc/dsd_decimator.md
Name: dsd_decimator

Overview:
- Converts an interleaved DSD byte stream (CHANNELS channels) into signed PCM samples. It uses one 4th-order CIC decimator per channel, with decimation DECIM = 2**LOG2_DECIM.
- Sits between the file/stream fetch logic and the audio output path of the DSD player core.
- Successor to the fixed test-pattern source: channel count, decimation ratio, output width and bit order are all configurable.

Parameters:
- CHANNELS, 2: number of interleaved channels (1..8).
- LOG2_DECIM, 5: log2 of DSD bits per PCM sample. Default is 32, i.e. DSD64 → 88.2 kHz.
- OUT_W, 16: PCM output width. Constraint: OUT_W-1 <= 4*LOG2_DECIM.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush: channel pointer, byte buffers, bit counter, CIC state, decimation counter
- enable  in  1  1 = ticks are consumed; 0 = ticks ignored, all state held
- lsb_first  in  1  0 = MSB first (DSDIFF), 1 = LSB first (DSF). Sampled only at byte load.
- dsd_tick  in  1  one-cycle strobe, one DSD bit period
- in_valid  in  1  input byte valid
- in_ready  out  1  input byte accepted when in_valid & in_ready
- in_data  in  8  DSD byte; channel order 0..CHANNELS-1 repeating
- pcm_valid  out  1  one-cycle strobe, new sample on pcm
- pcm  out  CHANNELS*OUT_W  packed signed samples, channel 0 in LSBs
- underrun_cnt  out  16  saturating count of byte-slot underruns

Behaviour:

Reset (async) and clear (sync) produce the same state:
- chan_ptr=0, next_full=0, cur[ch]=8'h69, bitpos=0, dec_cnt=0.
- All integrators and comb delays 0.
- pcm=0, pcm_valid=0.
- underrun_cnt=0 on reset only; clear does not touch it.

Fetch:
- in_ready = !next_full (combinational).
- On accept: next[chan_ptr] <= in_data and chan_ptr increments.
- When chan_ptr = CHANNELS-1 is accepted: chan_ptr <= 0 and next_full <= 1.

Play (on dsd_tick & enable):
- bit b[ch] = cur[ch][lsb_first ? bitpos : 7-bitpos]; x = b ? +1 : -1.
- bitpos increments mod 8.
- When bitpos wraps 7→0:
  - If next_full: cur <= next and next_full <= 0. in_ready rises the following cycle, so there is no accept in the same cycle.
  - Otherwise: cur <= 8'h69 for all channels and underrun_cnt++ (saturating at 16'hFFFF). Any partially filled next bytes are kept.
- Ticks arriving while enable=0 or clear=1 are dropped.

CIC (per channel):
- Internal width W = 4*LOG2_DECIM+2, two's complement with intentional modular wrap.
- 4 integrators update on every consumed tick.
- dec_cnt counts consumed ticks mod DECIM. On the tick where dec_cnt = DECIM-1:
  - feed integrator 4 through 4 combs (differential delay 1), computed in one cycle;
  - on the next cycle, pcm_valid=1 for one cycle and pcm is updated.
- Scaling: y = comb_out >>> (4*LOG2_DECIM-(OUT_W-1)) (arithmetic shift), then saturated to [-2**(OUT_W-1), 2**(OUT_W-1)-1].
- Latency: pcm_valid comes 1 clk after the DECIM-th tick. The first sample follows the DECIM-th consumed tick after reset or clear.

Simultaneous events:
- clear wins over tick and accept.
- Accept and tick in the same cycle are both processed.

Decomposition:
- Package dsd_pkg:
  - CIC_ORDER=4;
  - DSD_SILENCE=8'h69;
  - function cic_width(log2_decim) = 4*log2_decim+2;
  - function sat(value, out_w).
- Sub-module dsd_cic (one channel: integrators, combs, scale, saturate), instantiated CHANNELS times via generate. The top holds the fetch/play logic and dec_cnt.

Test Plan:
1. Defaults, 0xFF on both channels kept always available, tick every 4 clk → after warm-up (>=4*DECIM ticks), both channels' pcm = 32767 on every pcm_valid; pcm_valid every 32 ticks.
2. Ch0 always 0xFF, ch1 always 0x00 → steady state ch0=32767, ch1=-32768. Checks channel order and packing.
3. No input bytes, enable=1 → pcm settles to exactly 0 (0x69 pattern); underrun_cnt = 1 per 8 ticks; saturates at 65535 in a long run.
4. Byte 0x0F on all channels, lsb_first=0 vs lsb_first=1 → first integrator sequence over 8 ticks is -1×4,+1×4 vs +1×4,-1×4 (compare the integrator 1 trace).
5. Assert clear mid-stream, with CHANNELS=2 after only ch0 accepted → next byte accepted goes to ch0; no pcm_valid until 32 ticks after clear; underrun_cnt unchanged.
6. CHANNELS=6, LOG2_DECIM=6, OUT_W=24, all 0xFF → 8388607 on all six lanes; pcm_valid every 64 ticks.
